// File: rtl/bp_fe_instr_scan_block_if.sv
// Signal bundle between the fetch stage, the pre-decoder and the
// branch predictor / PC-gen consumer. The block uses the slave view.
interface bp_fe_instr_scan_block_if #(
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2
);
  localparam int idx_width_lp = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;

  logic                                     flush_i;
  logic                                     fetch_v_i;
  logic                                     fetch_ready_o;
  logic [eaddr_width_p-1:0]                 fetch_pc_i;
  logic [fetch_width_p*instr_width_p-1:0]   fetch_instr_i;
  logic                                     scan_v_o;
  logic                                     scan_yumi_i;
  logic [eaddr_width_p-1:0]                 scan_pc_o;
  logic [fetch_width_p*3-1:0]               scan_class_o;
  logic [fetch_width_p*eaddr_width_p-1:0]   scan_imm_o;
  logic [fetch_width_p-1:0]                 scan_compressed_o;
  logic                                     first_cf_v_o;
  logic [idx_width_lp-1:0]                  first_cf_idx_o;
  logic                                     first_cf_indirect_o;
  logic [eaddr_width_p-1:0]                 first_cf_target_o;

  modport slave (
    input  flush_i, fetch_v_i, fetch_pc_i, fetch_instr_i, scan_yumi_i,
    output fetch_ready_o, scan_v_o, scan_pc_o, scan_class_o, scan_imm_o,
           scan_compressed_o, first_cf_v_o, first_cf_idx_o,
           first_cf_indirect_o, first_cf_target_o
  );

  modport master (
    output flush_i, fetch_v_i, fetch_pc_i, fetch_instr_i, scan_yumi_i,
    input  fetch_ready_o, scan_v_o, scan_pc_o, scan_class_o, scan_imm_o,
           scan_compressed_o, first_cf_v_o, first_cf_idx_o,
           first_cf_indirect_o, first_cf_target_o
  );
endinterface

// File: rtl/bp_fe_instr_scan_block.sv
// Front-end instruction pre-decoder. Each fetch packet is classified slot
// by slot on the input side; the decoded packet is parked in a 2-entry FIFO
// so the consumer sees only registered fields.
module bp_fe_instr_scan_block #(
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_fe_instr_scan_block_if.slave scan_if
);
  localparam int idx_width_lp   = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;
  localparam int class_width_lp = fetch_width_p * 3;
  localparam int imm_width_lp   = fetch_width_p * eaddr_width_p;

  localparam logic [6:0] op_branch_lp = 7'b1100011;
  localparam logic [6:0] op_jalr_lp   = 7'b1100111;
  localparam logic [6:0] op_jal_lp    = 7'b1101111;

  localparam logic [2:0] class_default_lp = 3'd0;
  localparam logic [2:0] class_branch_lp  = 3'd1;
  localparam logic [2:0] class_jalr_lp    = 3'd2;
  localparam logic [2:0] class_jal_lp     = 3'd3;
  localparam logic [2:0] class_call_lp    = 3'd4;
  localparam logic [2:0] class_ret_lp     = 3'd5;

  logic [class_width_lp-1:0] w_class;
  logic [imm_width_lp-1:0]   w_imm;
  logic [fetch_width_p-1:0]  w_comp;
  logic [fetch_width_p-1:0]  w_indirect;
  logic [eaddr_width_p-1:0]  w_tgt [fetch_width_p];

  for (genvar k = 0; k < fetch_width_p; k++) begin : g_slot
    localparam logic [eaddr_width_p-1:0] slot_off_lp = eaddr_width_p'(4 * k);

    logic [31:0]              w_instr;
    logic [6:0]               w_op;
    logic [4:0]               w_rd;
    logic [4:0]               w_rs1;
    logic                     w_is_br;
    logic                     w_is_jalr;
    logic                     w_is_jal;
    logic [2:0]               w_cls;
    logic [eaddr_width_p-1:0] w_slot_imm;
    logic                     w_unused_funct3;

    assign w_instr   = scan_if.fetch_instr_i[k*instr_width_p +: 32];
    assign w_op      = w_instr[6:0];
    assign w_rd      = w_instr[11:7];
    assign w_rs1     = w_instr[19:15];
    assign w_is_br   = (w_op == op_branch_lp);
    assign w_is_jalr = (w_op == op_jalr_lp);
    assign w_is_jal  = (w_op == op_jal_lp);
    assign w_unused_funct3 = ^w_instr[14:12];

    // Priority classification: link-register writes win over plain jumps
    always_comb begin
      w_cls = class_default_lp;
      if ((w_is_jal || w_is_jalr) && (w_rd == 5'd1))
        w_cls = class_call_lp;
      else if (w_is_jalr && (w_rd == 5'd0) && (w_rs1 == 5'd1))
        w_cls = class_ret_lp;
      else if (w_is_br)
        w_cls = class_branch_lp;
      else if (w_is_jalr)
        w_cls = class_jalr_lp;
      else if (w_is_jal)
        w_cls = class_jal_lp;
    end

    // Immediate format is chosen by opcode, so call-via-jalr gets the I-form
    always_comb begin
      w_slot_imm = '0;
      if (w_is_br)
        w_slot_imm = {{(eaddr_width_p-12){w_instr[31]}}, w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
      else if (w_is_jalr)
        w_slot_imm = {{(eaddr_width_p-12){w_instr[31]}}, w_instr[31:20]};
      else if (w_is_jal)
        w_slot_imm = {{(eaddr_width_p-20){w_instr[31]}}, w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};
    end

    assign w_class[k*3 +: 3]                   = w_cls;
    assign w_imm[k*eaddr_width_p +: eaddr_width_p] = w_slot_imm;
    assign w_comp[k]                           = (w_instr[1:0] != 2'b11);
    assign w_indirect[k]                       = w_is_jalr;
    assign w_tgt[k] = w_is_jalr ? '0 : (scan_if.fetch_pc_i + slot_off_lp + w_slot_imm);
  end

  logic                     w_cf_v;
  logic [idx_width_lp-1:0]  w_cf_idx;
  logic                     w_cf_ind;
  logic [eaddr_width_p-1:0] w_cf_tgt;

  // Walk slots from the top down so the lowest control-flow slot wins
  always_comb begin
    w_cf_v   = 1'b0;
    w_cf_idx = '0;
    w_cf_ind = 1'b0;
    w_cf_tgt = '0;
    for (int k = fetch_width_p - 1; k >= 0; k--) begin
      if (w_class[k*3 +: 3] != class_default_lp) begin
        w_cf_v   = 1'b1;
        w_cf_idx = idx_width_lp'(k);
        w_cf_ind = w_indirect[k];
        w_cf_tgt = w_tgt[k];
      end
    end
  end

  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_ready;
  logic       w_enq;
  logic       w_deq;

  logic [eaddr_width_p-1:0]  r_pc_q     [2];
  logic [class_width_lp-1:0] r_class_q  [2];
  logic [imm_width_lp-1:0]   r_imm_q    [2];
  logic [fetch_width_p-1:0]  r_comp_q   [2];
  logic                      r_cf_v_q   [2];
  logic [idx_width_lp-1:0]   r_cf_idx_q [2];
  logic                      r_cf_ind_q [2];
  logic [eaddr_width_p-1:0]  r_cf_tgt_q [2];

  // Ready looks only at the registered count, so a full FIFO refuses a
  // packet even when the consumer drains in the same cycle
  assign w_ready = (r_count != 2'd2);
  assign w_enq   = scan_if.fetch_v_i & w_ready;
  assign w_deq   = scan_if.scan_yumi_i & (r_count != 2'd0);

  // Pointer and occupancy tracking; flush beats both enqueue and dequeue
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (scan_if.flush_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; cleared on reset only to keep the outputs X-free
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int e = 0; e < 2; e++) begin
        r_pc_q[e]     <= '0;
        r_class_q[e]  <= '0;
        r_imm_q[e]    <= '0;
        r_comp_q[e]   <= '0;
        r_cf_v_q[e]   <= 1'b0;
        r_cf_idx_q[e] <= '0;
        r_cf_ind_q[e] <= 1'b0;
        r_cf_tgt_q[e] <= '0;
      end
    end else if (w_enq && !scan_if.flush_i) begin
      r_pc_q[r_wptr]     <= scan_if.fetch_pc_i;
      r_class_q[r_wptr]  <= w_class;
      r_imm_q[r_wptr]    <= w_imm;
      r_comp_q[r_wptr]   <= w_comp;
      r_cf_v_q[r_wptr]   <= w_cf_v;
      r_cf_idx_q[r_wptr] <= w_cf_idx;
      r_cf_ind_q[r_wptr] <= w_cf_ind;
      r_cf_tgt_q[r_wptr] <= w_cf_tgt;
    end
  end

  assign scan_if.fetch_ready_o       = w_ready & ~reset_i;
  assign scan_if.scan_v_o            = (r_count != 2'd0);
  assign scan_if.scan_pc_o           = r_pc_q[r_rptr];
  assign scan_if.scan_class_o        = r_class_q[r_rptr];
  assign scan_if.scan_imm_o          = r_imm_q[r_rptr];
  assign scan_if.scan_compressed_o   = r_comp_q[r_rptr];
  assign scan_if.first_cf_v_o        = (r_count != 2'd0) & r_cf_v_q[r_rptr];
  assign scan_if.first_cf_idx_o      = r_cf_idx_q[r_rptr];
  assign scan_if.first_cf_indirect_o = r_cf_ind_q[r_rptr];
  assign scan_if.first_cf_target_o   = r_cf_tgt_q[r_rptr];

  // A yumi with nothing at the head is a consumer bug
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    scan_if.scan_yumi_i |-> scan_if.scan_v_o);

endmodule
